// File: rtl/cmul_arbiter.sv
// Round-robin arbiter sharing one pipelined complex multiplier between NREQ requesters.
// Optional tag/valid cross-check against mul_rvalid: define CMUL_ARB_TAGCHK_EN.
module cmul_arbiter #(
   parameter int NREQ = 4,
   parameter int size = 16,
   parameter int LAT  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*size-1:0] req_a,
   input  logic [NREQ*size-1:0] req_b,
   output logic                 mul_a_valid,
   output logic                 mul_b_valid,
   output logic [size-1:0]      mul_a,
   output logic [size-1:0]      mul_b,
   input  logic                 mul_rvalid,
   input  logic [3*size-1:0]    mul_result,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [3*size-1:0]    rsp_result,
   output logic                 idle,
   output logic                 error
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state;
   logic [PW-1:0]       ptr, gidx;
   logic [PW:0]         idx;
   logic                gnt;
   logic [LAT:0]        vld_pipe;
   logic [LAT:0][PW-1:0] tag_pipe;
   logic                in_flight, fire;

   assign in_flight   = |vld_pipe;
   assign mul_b_valid = mul_a_valid;

   // First valid requester at or after ptr, wrapping; en gates the grant in the same cycle.
   always_comb begin
      req_ready = '0;
      gidx      = '0;
      gnt       = 1'b0;
      idx       = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (!gnt && state == RUN && en && req_valid[idx[PW-1:0]]) begin
            gnt  = 1'b1;
            gidx = idx[PW-1:0];
         end
      end
      if (gnt) req_ready[gidx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idle  <= 1'b1;
      end else begin
         case (state)
            IDLE:  if (en) begin
                      state <= RUN;
                      idle  <= 1'b0;
                   end
            RUN:   if (!en) state <= DRAIN;
            DRAIN: if (en) state <= RUN;
                   else if (!in_flight) begin
                      state <= IDLE;
                      idle  <= 1'b1;
                   end
            default: begin
               state <= IDLE;
               idle  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         mul_a_valid <= 1'b0;
         mul_a       <= '0;
         mul_b       <= '0;
      end else begin
         mul_a_valid <= gnt;
         if (gnt) begin
            mul_a <= req_a[gidx*size +: size];
            mul_b <= req_b[gidx*size +: size];
            ptr   <= (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
         end
      end
   end

   // Stage k holds a tag issued k+1 cycles ago; the tail lines up with mul_rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LAT-1:0], gnt};
         tag_pipe <= {tag_pipe[LAT-1:0], gidx};
      end
   end

`ifdef CMUL_ARB_TAGCHK_EN
   assign fire = vld_pipe[LAT] & mul_rvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          error <= 1'b0;
      else if (vld_pipe[LAT] != mul_rvalid) error <= 1'b1;
   end
`else
   logic unused_rvalid;
   assign unused_rvalid = mul_rvalid;
   assign fire          = vld_pipe[LAT];
   assign error         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= '0;
         rsp_result <= '0;
      end else begin
         rsp_valid <= '0;
         if (fire) begin
            rsp_valid[tag_pipe[LAT]] <= 1'b1;
            rsp_result               <= mul_result;
         end
      end
   end
endmodule
